// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryption core. One Cipher() sub-step per clock:
// LOAD, then ARK / SUB / SHIFT / MIX0..MIX3 per round, with the round key
// expanded forward on the fly in the SUB cycle. START/DONE level handshake.
module aes_encrypt_core #(
  parameter int NR = 10  // only 10 (AES-128) is legal
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AES_START,
  output logic         AES_DONE,
  input  logic [127:0] AES_KEY,
  input  logic [127:0] AES_MSG_PLAIN,
  output logic [127:0] AES_MSG_ENC
);

  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [3:0] {
    IDLE, LOAD, ARK, SUB, SHIFT, MIX0, MIX1, MIX2, MIX3, DONE
  } state_t;

  state_t       state, next_state;
  logic [127:0] st;     // cipher state, column c = [127-32c -: 32]
  logic [127:0] rk;     // current round key
  logic [3:0]   round;

  // GF(2^8) multiply by x, polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as affine(b^254); b^254 is the multiplicative inverse and maps 0 to 0.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Row r of the result takes its byte from column (c+r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a [4];
    logic [31:0] o;
    for (int r = 0; r < 4; r++) a[r] = col[31-8*r -: 8];
    for (int r = 0; r < 4; r++)
      o[31-8*r -: 8] = xtime(a[r]) ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4] ^
                       a[(r+2)%4] ^ a[(r+3)%4];
    return o;
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rcon, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1B;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and handshake output decode.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latches).
    next_state = state;
    AES_DONE   = 1'b0;
    case (state)
      IDLE:    if (AES_START) next_state = LOAD;
      LOAD:    next_state = ARK;
      ARK:     next_state = (round == NR_L) ? DONE : SUB;
      SUB:     next_state = SHIFT;
      SHIFT:   next_state = (round < NR_L) ? MIX0 : ARK;
      MIX0:    next_state = MIX1;
      MIX1:    next_state = MIX2;
      MIX2:    next_state = MIX3;
      MIX3:    next_state = ARK;
      DONE: begin
        AES_DONE = 1'b1;
        if (!AES_START) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: one cipher sub-step per state; key expansion shares the SUB cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: every datapath register is reset so no stale state or key survives an abort.
      st          <= '0;
      rk          <= '0;
      round       <= '0;
      AES_MSG_ENC <= '0;
    end else begin
      case (state)
        LOAD: begin
          st          <= AES_MSG_PLAIN;
          rk          <= AES_KEY;
          round       <= '0;
          AES_MSG_ENC <= '0;
        end
        ARK: begin
          st <= st ^ rk;
          if (round == NR_L) AES_MSG_ENC <= st ^ rk;
          else               round       <= round + 4'd1;
        end
        SUB: begin
          st <= sub_bytes(st);
          rk <= key_exp(rk, rcon_of(round));
        end
        SHIFT:   st <= shift_rows(st);
        MIX0:    st[127:96] <= mix_column(st[127:96]);
        MIX1:    st[95:64]  <= mix_column(st[95:64]);
        MIX2:    st[63:32]  <= mix_column(st[63:32]);
        MIX3:    st[31:0]   <= mix_column(st[31:0]);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Self-checking bench for aes_encrypt_core: FIPS-197 vectors, handshake,
// mid-run reset, input changes mid-run, and random vectors against a
// table-driven byte-array AES model.
module tb_aes_encrypt_core;

  logic         CLK;
  logic         RESET;
  logic         AES_START;
  logic         AES_DONE;
  logic [127:0] AES_KEY;
  logic [127:0] AES_MSG_PLAIN;
  logic [127:0] AES_MSG_ENC;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK1 = 128'ha0fafe1788542cb123a339392a6c7605;

  aes_encrypt_core #(.NR(10)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .AES_START     (AES_START),
    .AES_DONE      (AES_DONE),
    .AES_KEY       (AES_KEY),
    .AES_MSG_PLAIN (AES_MSG_PLAIN),
    .AES_MSG_ENC   (AES_MSG_ENC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model (log/antilog tables, byte arrays) -------
  logic [7:0] exp_t [256];
  logic [7:0] log_t [256];
  logic [7:0] sb    [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(int'(log_t[a]) + int'(log_t[b])) % 255];
  endfunction

  task automatic init_tables();
    logic [7:0] e;
    logic [7:0] inv;
    logic [7:0] cst;
    logic [7:0] s;
    e = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = e;
      log_t[e] = 8'(i);
      e = e ^ {e[6:0], 1'b0} ^ (e[7] ? 8'h1B : 8'h00);  // e * 3
    end
    exp_t[255] = exp_t[0];
    log_t[0]   = 8'h00;
    cst = 8'h63;
    for (int b = 0; b < 256; b++) begin
      inv = (b == 0) ? 8'h00 : exp_t[(255 - int'(log_t[b])) % 255];
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sb[b] = s;
    end
  endtask

  function automatic logic [127:0] ref_aes(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   a [4];
    logic [31:0]  tw;
    logic [7:0]   rc;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]], sb[tw[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = pt[127-8*(4*c+r) -: 8];
    for (int rnd = 0; rnd <= 10; rnd++) begin
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) t[r][c] = sb[s[r][c]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) s[r][c] = t[r][(c+r)%4];
        if (rnd < 10)
          for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[r][c];
            for (int r = 0; r < 4; r++)
              s[r][c] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
          end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  // ---------------- helpers --------------------------------------------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_pulse();
    RESET     = 1'b1;
    AES_START = 1'b0;
    tick();
    RESET = 1'b0;
    tick();
  endtask

  // Start a run from IDLE; lat = edges from E0 until AES_DONE is seen (200 = timeout).
  task automatic run_op(input logic [127:0] key, input logic [127:0] pt,
                        input int drop_at, input int change_at, input bit probe,
                        output int lat);
    AES_KEY       = key;
    AES_MSG_PLAIN = pt;
    AES_START     = 1'b1;
    tick();  // E0
    lat = 0;
    while (lat < 200) begin
      tick();
      lat++;
      if (probe && lat == 3) check("rk_after_sub1", dut.rk, RK1);
      if (lat == drop_at) AES_START = 1'b0;
      if (lat == change_at) begin
        AES_KEY       = {$urandom(), $urandom(), $urandom(), $urandom()};
        AES_MSG_PLAIN = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (AES_DONE) break;
    end
  endtask

  // ---------------- stimulus -------------------------------------------------
  initial begin
    int lat;
    logic [127:0] k, p;
    init_tables();
    RESET         = 1'b1;
    AES_START     = 1'b0;
    AES_KEY       = '0;
    AES_MSG_PLAIN = '0;
    repeat (3) tick();
    check("reset_done", 128'(AES_DONE), 128'd0);
    check("reset_enc", AES_MSG_ENC, 128'd0);
    RESET = 1'b0;
    tick();

    // Vector 1, latency, then hold START through DONE.
    run_op(K1, P1, -1, -1, 1'b0, lat);
    check("v1_latency", 128'(lat), 128'd68);
    check("v1_ct", AES_MSG_ENC, C1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_done", 128'(AES_DONE), 128'd1);
      check("hold_ct", AES_MSG_ENC, C1);
    end
    AES_START = 1'b0;
    tick();
    check("drop_done", 128'(AES_DONE), 128'd0);
    AES_START = 1'b1;
    tick();
    tick();
    check("load_clears_enc", AES_MSG_ENC, 128'd0);
    reset_pulse();

    // Vector 2 with round-key probe.
    run_op(K2, P2, -1, -1, 1'b1, lat);
    check("v2_latency", 128'(lat), 128'd68);
    check("v2_ct", AES_MSG_ENC, C2);
    AES_START = 1'b0;
    tick();
    check("v2_idle", 128'(AES_DONE), 128'd0);

    // Inputs change after LOAD: result unaffected.
    run_op(K2, P2, -1, 5, 1'b0, lat);
    check("v2_chg_ct", AES_MSG_ENC, C2);
    AES_START = 1'b0;
    tick();

    // START dropped early: DONE for exactly one cycle.
    run_op(K1, P1, 9, -1, 1'b0, lat);
    check("drop_latency", 128'(lat), 128'd68);
    check("drop_ct", AES_MSG_ENC, C1);
    tick();
    check("drop_done_1cyc", 128'(AES_DONE), 128'd0);
    tick();
    check("drop_stays_idle", 128'(AES_DONE), 128'd0);

    // Reset at E30 mid-run, then restart.
    AES_KEY       = K1;
    AES_MSG_PLAIN = P1;
    AES_START     = 1'b1;
    tick();  // E0
    repeat (29) tick();
    RESET = 1'b1;
    tick();  // E30
    check("rst_mid_done", 128'(AES_DONE), 128'd0);
    check("rst_mid_enc", AES_MSG_ENC, 128'd0);
    check("rst_mid_st", dut.st, 128'd0);
    check("rst_mid_rk", dut.rk, 128'd0);
    RESET     = 1'b0;
    AES_START = 1'b0;
    tick();
    run_op(K1, P1, -1, -1, 1'b0, lat);
    check("rst_restart_latency", 128'(lat), 128'd68);
    check("rst_restart_ct", AES_MSG_ENC, C1);
    AES_START = 1'b0;
    tick();

    // Random vectors against the reference model.
    for (int n = 0; n < 8; n++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      p = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_op(k, p, -1, -1, 1'b0, lat);
      check("rand_latency", 128'(lat), 128'd68);
      check("rand_ct", AES_MSG_ENC, ref_aes(k, p));
      AES_START = 1'b0;
      tick();
      check("rand_idle", 128'(AES_DONE), 128'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
